// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the
// memory stage and the DMA/program-loader port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_DMA
  } grant_t;

  localparam int WAIT_W           = 4;
  localparam int DEFAULT_MAX_WAIT = 3;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage (priority)
// and a DMA port, with a starvation counter that forces a DMA slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CpuReqM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  input  logic              DmaValid,
  input  logic              DmaWE,
  input  logic [ADDR_W-1:0] DmaAddr,
  input  logic [DATA_W-1:0] DmaWD,
  output logic              DmaReady,
  output logic [DATA_W-1:0] DmaRData,
  output logic              DmaRValid,
  output logic              WE,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] RD
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  grant_t            grant;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  // Grant decode and starvation counter; the counter only survives lost conflicts.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant      = GNT_NONE;
    wait_cnt_d = '0;
    if (!rst) begin
      if (CpuReqM && DmaValid) begin
        if (wait_cnt_q == MaxWait) begin
          grant = GNT_DMA;
        end else begin
          grant      = GNT_CPU;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else if (CpuReqM) begin
        grant = GNT_CPU;
      end else if (DmaValid) begin
        grant = GNT_DMA;
      end
    end
  end

  always_comb begin
    WE       = 1'b0;
    A        = ALUResultM;
    WD       = WriteDataM;
    DmaReady = 1'b0;
    StallM   = 1'b0;
    unique case (grant)
      GNT_CPU: WE = MemWriteM;
      GNT_DMA: begin
        WE       = DmaWE;
        A        = DmaAddr;
        WD       = DmaWD;
        DmaReady = 1'b1;
        // Only a forced grant takes the slot from a requesting CPU.
        StallM   = CpuReqM;
      end
      default: ;
    endcase
  end

  assign ReadDataM = RD;

  always_comb begin
    dma_rvalid_d = DmaValid && DmaReady && !DmaWE;
    dma_rdata_d  = dma_rvalid_d ? RD : dma_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign DmaRValid = dma_rvalid_q;
  assign DmaRData  = dma_rdata_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, a behavioural
// memory, and a cycle-by-cycle reference model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          CpuReqM, MemWriteM;
  logic [AW-1:0] ALUResultM;
  logic [DW-1:0] WriteDataM, ReadDataM;
  logic          StallM;
  logic          DmaValid, DmaWE;
  logic [AW-1:0] DmaAddr;
  logic [DW-1:0] DmaWD, DmaRData;
  logic          DmaReady, DmaRValid;
  logic          WE;
  logic [AW-1:0] A;
  logic [DW-1:0] WD, RD;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .CpuReqM(CpuReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .DmaValid(DmaValid), .DmaWE(DmaWE), .DmaAddr(DmaAddr), .DmaWD(DmaWD),
    .DmaReady(DmaReady), .DmaRData(DmaRData), .DmaRValid(DmaRValid),
    .WE(WE), .A(A), .WD(WD), .RD(RD)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: async read, sync write, word addressed.
  logic [DW-1:0] dev_mem [0:255] = '{default: '0};
  assign RD = dev_mem[A[9:2]];
  always @(posedge clk) if (WE) dev_mem[A[9:2]] <= WD;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, run of consecutive lost conflicts, pending read return.
  logic [DW-1:0] model_mem [0:255] = '{default: '0};
  int            m_lost   = 0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata  = '0;

  always @(negedge clk) begin
    logic          dma_turn, cpu_turn, exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_wd;
    if (rst) begin
      check("m_rst_we", WE, 0);
      check("m_rst_ready", DmaReady, 0);
      check("m_rst_stall", StallM, 0);
      check("m_rst_rvalid", DmaRValid, 0);
      check("m_rst_rdata", DmaRData, 0);
      m_lost   = 0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
    end else begin
      dma_turn = DmaValid && (!CpuReqM || m_lost >= MW);
      cpu_turn = CpuReqM && !dma_turn;
      exp_we   = cpu_turn ? MemWriteM : (dma_turn ? DmaWE : 1'b0);
      exp_a    = dma_turn ? DmaAddr : ALUResultM;
      exp_wd   = dma_turn ? DmaWD : WriteDataM;
      check("m_we", WE, exp_we);
      check("m_ready", DmaReady, dma_turn);
      check("m_stall", StallM, dma_turn && CpuReqM);
      if (exp_we || cpu_turn || dma_turn) begin
        check("m_addr", A, exp_a);
        if (exp_we) check("m_wd", WD, exp_wd);
      end
      if (cpu_turn && !MemWriteM) check("m_rdm", ReadDataM, model_mem[ALUResultM[9:2]]);
      check("m_rvalid", DmaRValid, m_rvalid);
      if (m_rvalid) check("m_rdata", DmaRData, m_rdata);
      // State after the coming edge.
      m_lost   = (CpuReqM && DmaValid && !dma_turn) ? m_lost + 1 : 0;
      m_rvalid = dma_turn && !DmaWE;
      if (m_rvalid) m_rdata = model_mem[DmaAddr[9:2]];
      if (exp_we) model_mem[exp_a[9:2]] = exp_wd;
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CpuReqM = req; MemWriteM = we; ALUResultM = a; WriteDataM = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    DmaValid = v; DmaWE = we; DmaAddr = a; DmaWD = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stall_v, ready_v;

  initial begin
    rst = 1'b1;
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    @(negedge clk);
    check("reset_we", WE, 0);
    check("reset_rvalid", DmaRValid, 0);
    next_cycle();
    rst = 1'b0;

    // CPU store then load.
    set_cpu(1, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    check("cpu_store_we", WE, 1);
    check("cpu_store_stall", StallM, 0);
    next_cycle();
    set_cpu(1, 0, 32'h40, '0);
    @(negedge clk);
    check("cpu_load_data", ReadDataM, 32'hDEADBEEF);
    check("cpu_load_stall", StallM, 0);
    next_cycle();

    // DMA-only read.
    set_cpu(0, 0, '0, '0);
    set_dma(1, 0, 32'h40, '0);
    @(negedge clk);
    check("dma_rd_ready", DmaReady, 1);
    check("dma_rd_we", WE, 0);
    next_cycle();
    set_dma(0, 0, '0, '0);
    @(negedge clk);
    check("dma_rd_rvalid", DmaRValid, 1);
    check("dma_rd_data", DmaRData, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("dma_rd_pulse_end", DmaRValid, 0);
    next_cycle();

    // Continuous conflict: DMA forced in every fourth cycle.
    set_cpu(1, 0, 32'h00, '0);
    set_dma(1, 0, 32'h44, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stall_v[i] = StallM;
      ready_v[i] = DmaReady;
      next_cycle();
    end
    check("conflict_stall", stall_v, 8'b1000_1000);
    check("conflict_ready", ready_v, 8'b1000_1000);

    // DMA write to 0x80 wins at WaitCnt==3, CPU then reads the new value.
    set_cpu(1, 0, 32'h80, '0);
    set_dma(1, 1, 32'h80, 32'h12345678);
    @(negedge clk);
    check("dw_cpu_old", ReadDataM, 32'h0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("dw_forced_we", WE, 1);
    check("dw_forced_a", A, 32'h80);
    check("dw_forced_stall", StallM, 1);
    next_cycle();
    set_dma(0, 0, '0, '0);
    @(negedge clk);
    check("dw_cpu_new", ReadDataM, 32'h12345678);
    check("dw_no_rvalid", DmaRValid, 0);
    check("dw_cpu_stall", StallM, 0);
    next_cycle();

    // Conflict broken by an idle CPU at WaitCnt==2.
    set_cpu(1, 0, 32'h40, '0);
    set_dma(1, 0, 32'h40, '0);
    next_cycle();
    next_cycle();
    set_cpu(0, 0, '0, '0);
    @(negedge clk);
    check("brk_ready", DmaReady, 1);
    check("brk_stall", StallM, 0);
    next_cycle();
    set_cpu(1, 0, 32'h40, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ready_v[i] = DmaReady;
      next_cycle();
    end
    check("brk_cnt_cleared", ready_v[3:0], 4'b1000);

    // Async reset in the cycle after a DMA read transfer.
    set_cpu(0, 0, '0, '0);
    set_dma(1, 0, 32'h40, '0);
    next_cycle();
    set_dma(1, 1, 32'h40, 32'h0BAD0BAD);
    set_cpu(1, 1, 32'h40, 32'h0BAD0BAD);
    check("rst_pre_rvalid", DmaRValid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_rvalid_drop", DmaRValid, 0);
    check("rst_rdata_clr", DmaRData, 0);
    check("rst_we", WE, 0);
    check("rst_ready", DmaReady, 0);
    check("rst_stall", StallM, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    set_dma(1, 0, 32'h44, '0);
    set_cpu(1, 0, 32'h40, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ready_v[i] = DmaReady;
      if (i == 0) check("rst_no_write", ReadDataM, 32'hDEADBEEF);
      next_cycle();
    end
    check("rst_restart_prio", ready_v[3:0], 4'b1000);

    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    next_cycle();
    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter
